// File: rtl/ans_decoder_pkg.sv
// Shared ANS definitions: symbol/count/state widths, FSM encodings and the
// frequency-table slot test common to the encoder and decoder.
package ans_decoder_pkg;

    localparam int SYM_WIDTH   = 4;
    localparam int CNT_WIDTH   = 4;
    localparam int STATE_WIDTH = 16;
    localparam int CUM_WIDTH   = SYM_WIDTH + CNT_WIDTH;
    localparam int NUM_SYMS    = 1 << SYM_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_EMIT   = 3'd2,
        ST_RENORM = 3'd3,
        ST_ERROR  = 3'd4
    } ans_state_e;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] count;
        logic [CUM_WIDTH-1:0] cum;
    } freq_entry_t;

    // True when slot lies in [cum, cum+count) of a non-empty entry.
    function automatic logic slot_hit(input logic [STATE_WIDTH-1:0] slot,
                                      input logic [CUM_WIDTH-1:0]   cum,
                                      input logic [CNT_WIDTH-1:0]   count);
        logic [STATE_WIDTH-1:0] lo;
        logic [STATE_WIDTH-1:0] hi;
        lo = STATE_WIDTH'(cum);
        hi = lo + STATE_WIDTH'(count);
        return (count != '0) && (slot >= lo) && (slot < hi);
    endfunction

endpackage

// File: rtl/ans_decoder_freq_table.sv
// Symbol frequency table: one synchronous write port, one asynchronous
// indexed read port, cleared by synchronous reset.
module ans_freq_table
    import ans_decoder_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [SYM_WIDTH-1:0] waddr_i,
    input  logic [CNT_WIDTH-1:0] wcount_i,
    input  logic [CUM_WIDTH-1:0] wcum_i,
    input  logic [SYM_WIDTH-1:0] raddr_i,
    output logic [CNT_WIDTH-1:0] rcount_o,
    output logic [CUM_WIDTH-1:0] rcum_o
);

    freq_entry_t mem_q [NUM_SYMS];

    // Table storage: cleared on reset, otherwise written one entry at a time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SYMS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= '{count: wcount_i, cum: wcum_i};
        end
    end

    assign rcount_o = mem_q[raddr_i].count;
    assign rcum_o   = mem_q[raddr_i].cum;

endmodule

// File: rtl/ans_decoder.sv
// rANS decoder: linear table search per state, symbol emission with
// back-pressure, and chunk-wise renormalisation back into [M, 16M).
module ans_decoder
    import ans_decoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [STATE_WIDTH-1:0] total_count,
    input  logic                   tbl_we,
    input  logic [SYM_WIDTH-1:0]   tbl_addr,
    input  logic [CNT_WIDTH-1:0]   tbl_count,
    input  logic [CUM_WIDTH-1:0]   tbl_cumulative,
    input  logic [STATE_WIDTH-1:0] init_state,
    input  logic                   init_vld,
    input  logic [SYM_WIDTH-1:0]   in,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [SYM_WIDTH-1:0]   out,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   done,
    output logic                   err
);

    ans_state_e             fsm_q,       fsm_d;
    logic [STATE_WIDTH-1:0] state_reg_q, state_reg_d;
    logic [SYM_WIDTH-1:0]   idx_q,       idx_d;
    logic [SYM_WIDTH-1:0]   out_q,       out_d;
    logic                   err_q,       err_d;

    logic                   tbl_wr_s;
    logic [CNT_WIDTH-1:0]   rd_count_s;
    logic [CUM_WIDTH-1:0]   rd_cum_s;
    logic [STATE_WIDTH-1:0] slot_s;
    logic [STATE_WIDTH-1:0] quot_s;
    logic [STATE_WIDTH-1:0] next_state_s;
    logic [STATE_WIDTH-1:0] renorm_state_s;
    logic                   match_s;
    logic                   below_m_s;

    ans_freq_table u_table (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (tbl_wr_s),
        .waddr_i  (tbl_addr),
        .wcount_i (tbl_count),
        .wcum_i   (tbl_cumulative),
        .raddr_i  (idx_q),
        .rcount_o (rd_count_s),
        .rcum_o   (rd_cum_s)
    );

    assign slot_s         = state_reg_q % total_count;
    assign quot_s         = state_reg_q / total_count;
    assign match_s        = slot_hit(slot_s, rd_cum_s, rd_count_s);
    assign next_state_s   = STATE_WIDTH'(rd_count_s) * quot_s + slot_s - STATE_WIDTH'(rd_cum_s);
    assign renorm_state_s = (state_reg_q << SYM_WIDTH) | STATE_WIDTH'(in);
    assign below_m_s      = (state_reg_q < total_count);

    assign in_rdy  = !rst && (fsm_q == ST_RENORM) && below_m_s;
    assign out_vld = (fsm_q == ST_EMIT);
    assign out     = out_q;
    assign err     = err_q;
    // M+1 is where the encoder started, so reaching it means the stream is consumed.
    assign done    = (state_reg_q == total_count + STATE_WIDTH'(1)) &&
                     ((fsm_q == ST_SEARCH) || (fsm_q == ST_IDLE));

    // Next-state logic; with ena low every register keeps its value.
    always_comb begin
        fsm_d       = fsm_q;
        state_reg_d = state_reg_q;
        idx_d       = idx_q;
        out_d       = out_q;
        err_d       = err_q;
        tbl_wr_s    = 1'b0;
        if (ena) begin
            case (fsm_q)
                ST_IDLE, ST_ERROR: begin
                    tbl_wr_s = (fsm_q == ST_IDLE) && tbl_we;
                    if (init_vld) begin
                        state_reg_d = init_state;
                        idx_d       = '0;
                        err_d       = 1'b0;
                        fsm_d       = ST_SEARCH;
                    end else begin
                        fsm_d = fsm_q;
                    end
                end
                ST_SEARCH: begin
                    if (match_s) begin
                        out_d       = idx_q;
                        state_reg_d = next_state_s;
                        fsm_d       = ST_EMIT;
                    end else if (idx_q == SYM_WIDTH'(NUM_SYMS - 1)) begin
                        err_d = 1'b1;
                        fsm_d = ST_ERROR;
                    end else begin
                        idx_d = idx_q + SYM_WIDTH'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_rdy) begin
                        fsm_d = ST_RENORM;
                    end else begin
                        fsm_d = ST_EMIT;
                    end
                end
                ST_RENORM: begin
                    if (!below_m_s) begin
                        idx_d = '0;
                        fsm_d = ST_SEARCH;
                    end else if (in_vld) begin
                        state_reg_d = renorm_state_s;
                    end else begin
                        fsm_d = ST_RENORM;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                end
            endcase
        end else begin
            fsm_d = fsm_q;
        end
    end

    // State registers with synchronous reset to the encoder start state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_reg_q <= total_count + STATE_WIDTH'(1);
            idx_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_reg_q <= state_reg_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ans_decoder.sv
// Self-checking bench for ans_decoder: single-decode vector table, directed
// corner sequences, and randomized round trips against an rANS encoder model.
module tb_ans_decoder;

    logic        clk, rst, ena;
    logic [15:0] total_count;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [3:0]  tbl_count;
    logic [7:0]  tbl_cumulative;
    logic [15:0] init_state;
    logic        init_vld;
    logic [3:0]  in;
    logic        in_vld, in_rdy;
    logic [3:0]  out;
    logic        out_vld, out_rdy;
    logic        done, err;

    int checks;
    int errors;
    int mcnt [16];
    int mcum [16];
    int mm;
    int seq_q [$];
    int chunk_q [$];

    typedef struct packed {
        logic [15:0] init;
        logic [3:0]  sym;
        logic [7:0]  lat;
        logic [15:0] st;
        logic        rdy;
    } vec_t;
    vec_t vecs [8];

    ans_decoder dut (
        .clk(clk), .rst(rst), .ena(ena), .total_count(total_count),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_count(tbl_count),
        .tbl_cumulative(tbl_cumulative), .init_state(init_state),
        .init_vld(init_vld), .in(in), .in_vld(in_vld), .in_rdy(in_rdy),
        .out(out), .out_vld(out_vld), .out_rdy(out_rdy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; tbl_we = 1'b0; init_vld = 1'b0;
        in_vld = 1'b0; out_rdy = 1'b0; in = 4'd0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mcnt[i] = 0;
            mcum[i] = 0;
        end
    endtask

    task automatic write_tbl(input int i, input int c, input int cu);
        tbl_we = 1'b1; tbl_addr = i[3:0]; tbl_count = c[3:0]; tbl_cumulative = cu[7:0];
        mcnt[i] = c;
        mcum[i] = cu;
        step();
        tbl_we = 1'b0;
    endtask

    task automatic load_spec();
        write_tbl(0, 8, 0);
        write_tbl(1, 4, 8);
        write_tbl(2, 4, 12);
    endtask

    task automatic start(input int st);
        init_state = st[15:0];
        init_vld = 1'b1;
        step();
        init_vld = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_vld && n < 40);
    endtask

    // Reference rANS encoder (base-16 chunks, state interval [M,16M)).
    function automatic int encode();
        int x, s, c;
        x = mm + 1;
        chunk_q.delete();
        foreach (seq_q[k]) begin
            s = seq_q[k];
            c = mcnt[s];
            while (x >= 16 * c) begin
                chunk_q.push_back(x % 16);
                x = x / 16;
            end
            x = (x / c) * mm + mcum[s] + (x % c);
        end
        return x;
    endfunction

    // Drives chunks LIFO and collects symbols until done follows the last one.
    task automatic run_loop(input bit rnd);
        int got [$];
        int cyc;
        bit seen;
        int n;
        n = seq_q.size();
        cyc = 0;
        seen = 1'b0;
        while (cyc < 3000) begin
            if (got.size() == n && done) begin
                seen = 1'b1;
                break;
            end
            ena = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            out_rdy = (got.size() < n) ? (rnd ? ($urandom_range(0, 2) != 0) : 1'b1) : 1'b0;
            if (in_rdy && chunk_q.size() > 0) begin
                in_vld = 1'b1;
                in = chunk_q[$][3:0];
            end else begin
                in_vld = 1'b0;
            end
            if (ena && out_vld && out_rdy) got.push_back(int'(out));
            if (ena && in_rdy && in_vld) void'(chunk_q.pop_back());
            step();
            cyc++;
        end
        ena = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        chk("rt_count", got.size(), n);
        for (int k = 0; k < got.size() && k < n; k++) chk($sformatf("rt_sym%0d", k), got[k], seq_q[n-1-k]);
        chk("rt_done", seen, 1);
        chk("rt_chunks_left", chunk_q.size(), 0);
    endtask

    task automatic rand_table();
        int c [16];
        int i, acc;
        mm = $urandom_range(16, 60);
        total_count = mm[15:0];
        do_reset();
        for (int k = 0; k < 16; k++) c[k] = 0;
        for (int u = 0; u < mm; u++) begin
            do i = $urandom_range(0, 15); while (c[i] >= 15);
            c[i]++;
        end
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            if (c[k] > 0) write_tbl(k, c[k], acc);
            acc += c[k];
        end
    endtask

    initial begin
        int n, s, len, st;
        checks = 0; errors = 0;
        rst = 1'b1; ena = 1'b1; total_count = 16'd16; mm = 16;
        tbl_we = 1'b0; tbl_addr = 4'd0; tbl_count = 4'd0; tbl_cumulative = 8'd0;
        init_state = 16'd0; init_vld = 1'b0; in = 4'd0; in_vld = 1'b0; out_rdy = 1'b0;
        vecs[0] = '{16'd49,   4'd0, 8'd1, 16'd25,  1'b0};
        vecs[1] = '{16'd25,   4'd1, 8'd2, 16'd5,   1'b1};
        vecs[2] = '{16'd30,   4'd2, 8'd3, 16'd6,   1'b1};
        vecs[3] = '{16'd255,  4'd2, 8'd3, 16'd63,  1'b0};
        vecs[4] = '{16'd16,   4'd0, 8'd1, 16'd8,   1'b1};
        vecs[5] = '{16'd200,  4'd1, 8'd2, 16'd48,  1'b0};
        vecs[6] = '{16'd17,   4'd0, 8'd1, 16'd9,   1'b1};
        vecs[7] = '{16'd1000, 4'd1, 8'd2, 16'd248, 1'b0};

        do_reset();
        chk("rst_state", dut.state_reg_q, 17);
        chk("rst_done", done, 1);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_err", err, 0);
        chk("rst_out", out, 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            load_spec();
            start(int'(vecs[v].init));
            wait_out(n);
            chk($sformatf("vec%0d_lat", v), n, vecs[v].lat);
            chk($sformatf("vec%0d_out", v), out, vecs[v].sym);
            chk($sformatf("vec%0d_state", v), dut.state_reg_q, vecs[v].st);
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
            chk($sformatf("vec%0d_in_rdy", v), in_rdy, vecs[v].rdy);
        end

        // Back-pressure on 49, then continue into renormalisation.
        do_reset();
        load_spec();
        start(49);
        wait_out(n);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_out_vld", out_vld, 1);
            chk("bp_out", out, 0);
            chk("bp_state", dut.state_reg_q, 25);
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("s25_in_rdy_renorm", in_rdy, 0);
        step();
        chk("s25_in_rdy_search", in_rdy, 0);
        wait_out(n);
        chk("s25_lat", n, 2);
        chk("s25_out", out, 1);
        chk("s25_state", dut.state_reg_q, 5);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("rn_in_rdy", in_rdy, 1);
        in = 4'hA; in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        chk("rn_state", dut.state_reg_q, 90);
        chk("rn_in_rdy_after", in_rdy, 0);
        step();
        chk("rn_search_in_rdy", in_rdy, 0);
        wait_out(n);
        chk("s90_out", out, 1);
        chk("s90_state", dut.state_reg_q, 22);

        // Enable freeze in EMIT and in RENORM.
        do_reset();
        load_spec();
        start(25);
        wait_out(n);
        ena = 1'b0; out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ena_emit_vld", out_vld, 1);
            chk("ena_emit_out", out, 1);
            chk("ena_emit_state", dut.state_reg_q, 5);
            chk("ena_emit_in_rdy", in_rdy, 0);
        end
        ena = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("ena_renorm_in_rdy", in_rdy, 1);
        ena = 1'b0; in = 4'h3; in_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ena_rn_state", dut.state_reg_q, 5);
            chk("ena_rn_in_rdy", in_rdy, 1);
            chk("ena_rn_out_vld", out_vld, 0);
        end
        // Reset taken mid-RENORM with a chunk pending.
        rst = 1'b1; ena = 1'b1;
        #1;
        chk("rst_hi_in_rdy", in_rdy, 0);
        step();
        rst = 1'b0; in_vld = 1'b0;
        chk("rst_rn_state", dut.state_reg_q, 17);
        chk("rst_rn_in_rdy", in_rdy, 0);
        chk("rst_rn_done", done, 1);
        chk("rst_rn_out", out, 0);

        // Search miss with entry 2 emptied.
        do_reset();
        load_spec();
        write_tbl(2, 0, 0);
        start(30);
        n = 0;
        do begin
            step();
            n++;
        end while (!err && n < 40);
        chk("miss_cycles", n, 16);
        step();
        step();
        chk("miss_err_sticky", err, 1);
        chk("miss_in_rdy", in_rdy, 0);
        chk("miss_out_vld", out_vld, 0);
        chk("miss_out", out, 0);
        start(49);
        chk("miss_err_clear", err, 0);
        wait_out(n);
        chk("miss_recover_out", out, 0);

        // Round trip of 0,1,2,0 through the reference encoder.
        total_count = 16'd16; mm = 16;
        do_reset();
        load_spec();
        seq_q = '{0, 1, 2, 0};
        start(encode());
        run_loop(1'b0);

        // Randomized tables, totals, sequences, enable and back-pressure.
        for (int t = 0; t < 25; t++) begin
            rand_table();
            seq_q.delete();
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                do s = $urandom_range(0, 15); while (mcnt[s] == 0);
                seq_q.push_back(s);
            end
            st = encode();
            start(st);
            run_loop(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
